// File: rtl/turbo_pkg.sv
// -----------------------------------------------------------------------------
// turbo_pkg
// Shared definitions for the HPGP turbo receive path (turbo_sched, turbo_len,
// turbo_rx):
//   - pb_size codes (PB16 / PB136 / PB520 / reserved)
//   - PB lengths in 2-bit soft symbols
//   - scheduler FSM state encoding
//   - pb_len_lookup(): pb_size code -> PB length in symbols
// No ports; import with `import turbo_pkg::*;`.
// -----------------------------------------------------------------------------
package turbo_pkg;

    // Width of the length constants; matches the datapath address width.
    localparam int LEN_W = 12;

    typedef enum logic [1:0] {
        PB16   = 2'd0,
        PB136  = 2'd1,
        PB520  = 2'd2,
        PB_RSV = 2'd3
    } pb_size_e;

    // PB length in 2-bit soft symbols (bytes * 4 after turbo coding overhead).
    localparam logic [LEN_W-1:0] LEN_PB16  = 12'd64;
    localparam logic [LEN_W-1:0] LEN_PB136 = 12'd544;
    localparam logic [LEN_W-1:0] LEN_PB520 = 12'd2080;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WRITE  = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_WAIT   = 3'd3,
        ST_DONE   = 3'd4
    } sched_state_e;

    // The reserved code maps to the PB16 length; callers reject that code
    // before the result is ever used.
    function automatic logic [LEN_W-1:0] pb_len_lookup(input logic [1:0] code);
        logic [LEN_W-1:0] len;
        case (code)
            2'd0:    len = LEN_PB16;
            2'd1:    len = LEN_PB136;
            2'd2:    len = LEN_PB520;
            default: len = LEN_PB16;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/turbo_sched.sv
// -----------------------------------------------------------------------------
// turbo_sched
// Sequencing controller for the turbo receive interleaver datapath. Writes
// one PB of 2-bit soft symbols into the interleaver memory, then runs
// 2*max(cfg_iter,1) read passes alternating interleaved / de-interleaved,
// and pulses pb_done at the end.
//
// Ports
//   clk           in   system clock, rising edge
//   rst           in   asynchronous active-high reset
//   pb_size [2]   in   PB size code (0 PB16, 1 PB136, 2 PB520, 3 reserved)
//   cfg_iter[IW]  in   decoder iterations per PB (0 treated as 1)
//   din_vld       in   one symbol valid this cycle
//   pass_done     in   end-of-read-pass pulse from the datapath
//   wen           out  memory write enable
//   waddr  [AW]   out  memory write address
//   pb_len [AW]   out  active PB length in symbols
//   start         out  read-pass launch pulse
//   mod_int_dint  out  1 = interleaved pass, 0 = de-interleaved pass
//   busy          out  PB in progress
//   pb_done       out  PB finished pulse
//   err_size      out  reserved pb_size rejected pulse
//   ovf           out  symbol arrived while decoding pulse
//
// Handshake: din_vld and pass_done are valid-only (no back-pressure). A
// symbol is accepted whenever din_vld is high in IDLE (legal size) or WRITE;
// din_vld in any decoding state is reported on ovf and discarded. pass_done
// is only acted on in WAIT. All outputs are registered.
// -----------------------------------------------------------------------------
module turbo_sched
    import turbo_pkg::*;
#(
    parameter int AW = 12,
    parameter int IW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    pb_size,
    input  logic [IW-1:0] cfg_iter,
    input  logic          din_vld,
    input  logic          pass_done,
    output logic          wen,
    output logic [AW-1:0] waddr,
    output logic [AW-1:0] pb_len,
    output logic          start,
    output logic          mod_int_dint,
    output logic          busy,
    output logic          pb_done,
    output logic          err_size,
    output logic          ovf
);

    sched_state_e  state;
    logic [AW-1:0] wr_cnt;     // next write address inside the PB
    logic [IW:0]   pass_cnt;   // completed read passes
    logic [IW-1:0] iter_q;     // iterations latched with the first symbol

    logic [AW-1:0] len_sel;    // length for the size code on the port now
    logic [AW-1:0] last_addr;  // final write address of the active PB
    logic [IW:0]   pass_next;
    logic [IW:0]   pass_target;
    logic          size_rsv;

    always_comb begin
        len_sel   = AW'(pb_len_lookup(pb_size));
        last_addr = pb_len - 1'b1;
        pass_next = pass_cnt + 1'b1;
        size_rsv  = (pb_size == PB_RSV);
        // One iteration = one interleaved plus one de-interleaved pass.
        // Zero iterations is promoted to one so a PB always gets decoded.
        pass_target = {iter_q, 1'b0};
        if (iter_q == '0) begin
            pass_target = (IW+1)'(2);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            wr_cnt       <= '0;
            pass_cnt     <= '0;
            iter_q       <= '0;
            pb_len       <= AW'(LEN_PB16);
            wen          <= 1'b0;
            waddr        <= '0;
            start        <= 1'b0;
            mod_int_dint <= 1'b1;
            busy         <= 1'b0;
            pb_done      <= 1'b0;
            err_size     <= 1'b0;
            ovf          <= 1'b0;
        end else begin
            // Pulse outputs default low every cycle.
            wen      <= 1'b0;
            start    <= 1'b0;
            pb_done  <= 1'b0;
            err_size <= 1'b0;
            ovf      <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (din_vld) begin
                        if (size_rsv) begin
                            // Reject the whole PB: nothing is latched, the
                            // symbol is dropped and busy stays low.
                            err_size <= 1'b1;
                        end else begin
                            pb_len   <= len_sel;
                            iter_q   <= cfg_iter;
                            wen      <= 1'b1;
                            waddr    <= '0;
                            wr_cnt   <= AW'(1);
                            pass_cnt <= '0;
                            busy     <= 1'b1;
                            // A one-symbol PB is already complete after
                            // this write.
                            if (len_sel == AW'(1)) begin
                                state <= ST_LAUNCH;
                            end else begin
                                state <= ST_WRITE;
                            end
                        end
                    end
                end

                ST_WRITE: begin
                    if (din_vld) begin
                        wen    <= 1'b1;
                        waddr  <= wr_cnt;
                        wr_cnt <= wr_cnt + 1'b1;
                        if (wr_cnt == last_addr) begin
                            state <= ST_LAUNCH;
                        end
                    end
                end

                ST_LAUNCH: begin
                    if (din_vld) begin
                        ovf <= 1'b1;
                    end
                    // Even passes are interleaved, odd passes de-interleaved;
                    // the mode only changes here so it is stable for the
                    // whole pass.
                    start        <= 1'b1;
                    mod_int_dint <= ~pass_cnt[0];
                    state        <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (din_vld) begin
                        ovf <= 1'b1;
                    end
                    if (pass_done) begin
                        pass_cnt <= pass_next;
                        if (pass_next == pass_target) begin
                            state <= ST_DONE;
                        end else begin
                            state <= ST_LAUNCH;
                        end
                    end
                end

                ST_DONE: begin
                    if (din_vld) begin
                        ovf <= 1'b1;
                    end
                    pb_done <= 1'b1;
                    busy    <= 1'b0;
                    wr_cnt  <= '0;
                    state   <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/turbo_sched.md
# turbo_sched

Sequencing controller for the HPGP turbo receive interleaver datapath. Accepts one physical block (PB) of 2-bit soft symbols, generates the write addresses and enables into the interleaver memory, then runs a programmable number of decoder iterations as alternating interleaved and de-interleaved read passes. It issues each pass start, waits for the datapath's end-of-pass indication, and signals PB completion. It sits between the symbol front end and the turbo_rx datapath and replaces the length/enable generation done per PB today.

## Interface
- AW, 12, memory address / length width
- IW, 4, iteration-count width
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- pb_size  in  2  PB size code: 0 = PB16, 1 = PB136, 2 = PB520, 3 = reserved; sampled on first accepted symbol
- cfg_iter  in  IW  decoder iterations per PB; 0 is treated as 1; sampled with pb_size
- din_vld  in  1  one 2-bit symbol valid this cycle
- pass_done  in  1  one-cycle pulse from datapath at end of a read pass
- wen  out  1  memory write enable
- waddr  out  AW  memory write address
- pb_len  out  AW  active PB length in symbols: 64 / 544 / 2080
- start  out  1  one-cycle pulse that launches a read pass
- mod_int_dint  out  1  pass mode: 1 = interleaved, 0 = de-interleaved; held stable for the whole pass
- busy  out  1  high from first accepted symbol until pb_done
- pb_done  out  1  one-cycle pulse when the PB is finished
- err_size  out  1  one-cycle pulse when a PB is rejected because pb_size = 3
- ovf  out  1  one-cycle pulse when din_vld is dropped while decoding

## Operation
- FSM states:
  - IDLE: waiting for the first symbol of a PB.
  - WRITE: accepting symbols into memory.
  - LAUNCH: issuing a pass start.
  - WAIT: waiting for the datapath to finish the pass.
  - DONE: signalling PB completion.
- IDLE + din_vld:
  - pb_size ≠ 3: latch pb_size and cfg_iter, write the symbol at address 0, count = 1, go to WRITE. If pb_len would be 1 (never, for legal sizes), behave as below.
  - pb_size = 3: pulse err_size, drop the symbol, stay in IDLE.
- WRITE + din_vld: write at address count, then count++. When the write to address pb_len−1 is accepted, go to LAUNCH. Gaps in din_vld are allowed; there is no timeout.
- LAUNCH: one cycle. Pulse start; mod_int_dint = 1 on even pass index, 0 on odd. Go to WAIT.
- WAIT + pass_done: pass++. If pass = 2·max(cfg_iter,1), go to DONE; otherwise go to LAUNCH.
- DONE: one cycle. Pulse pb_done, clear busy, go to IDLE.
- din_vld in LAUNCH, WAIT or DONE: pulse ovf; no write.
- pass_done outside WAIT: ignored.
- Pass counter is IW+1 bits; the maximum is 30 passes.
- pb_len updates when pb_size is latched and holds until the next PB is latched.

## Timing
- All outputs are registered.
- Reset values: wen = 0, waddr = 0, pb_len = 64, start = 0, mod_int_dint = 1, busy = 0, pb_done = 0, err_size = 0, ovf = 0. State returns to IDLE and all counters clear.
- Write path: din_vld at cycle t gives wen = 1 with the matching waddr at t+1. err_size and ovf also appear at t+1.
- First start: if the last symbol is accepted at t, start pulses at t+2, one cycle after its write lands.
- Next action after pass_done at cycle p: the next start or pb_done pulses at p+2 (through LAUNCH or DONE). mod_int_dint changes on the same cycle as start.
- busy rises at t+1 after the first accepted symbol and falls on the same cycle as pb_done.
- A new PB can be accepted on the cycle after pb_done.
- Reset mid-operation: an immediate abort to the reset values. Partial PB data in memory is abandoned, and the next PB writes from address 0.

## Structure
- Shared package turbo_pkg holds:
  - pb_size codes PB16/PB136/PB520/PB_RSV;
  - length constants LEN_PB16 = 64, LEN_PB136 = 544, LEN_PB520 = 2080;
  - the FSM state enum;
  - a pb_len lookup function.
  turbo_len and turbo_rx use the same constants.
- Single module; no sub-module needed. The write counter and pass counter are inline.

## Test plan
- PB16 with cfg_iter = 1 and 64 back-to-back din_vld:
  - wen with waddr 0..63 on consecutive cycles;
  - start + mod_int_dint = 1 two cycles after the last symbol;
  - after pass_done, start + mod_int_dint = 0;
  - after the second pass_done, pb_done; busy low after pb_done.
- PB520 with cfg_iter = 3 and randomly gapped din_vld: exactly 2080 writes ending at waddr 2079, pb_len = 2080, 6 start pulses with mode pattern 1,0,1,0,1,0, then one pb_done.
- pb_size = 3 with din_vld: err_size pulse, no wen, busy stays 0; a following PB136 is accepted with waddr starting at 0 and pb_len = 544.
- din_vld pulses while in WAIT: one ovf pulse per din_vld, wen stays 0, and the pass count is unaffected. pass_done while in IDLE produces no start.
- cfg_iter = 0: exactly 2 passes. A cfg_iter change mid-PB has no effect until the next PB.
- rst asserted after 30 symbols of PB136: all outputs return to reset values immediately; the next PB16 completes normally from waddr 0.
